// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between requesters and the register-bank write arbiter.
// Holds the request buses, the stall input and the registered bank-side outputs.
interface reg_write_arbiter_if #(
    parameter int unsigned N    = 24,
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 4,
    parameter int unsigned CW   = 16
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*N-1:0]  req_data;
    logic               stall;
    logic [NREQ-1:0]    gnt;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [N-1:0]       wdata;
    logic [2**AW-1:0]   wen_vec;
    logic [CW-1:0]      wr_count;

    modport master (
        output req, req_addr, req_data, stall,
        input  gnt, we, waddr, wdata, wen_vec, wr_count
    );

    modport slave (
        input  req, req_addr, req_data, stall,
        output gnt, we, waddr, wdata, wen_vec, wr_count
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of the SIMD register bank.
// Grant is combinational; the winning write is registered and decoded to per-register enables.
module reg_write_arbiter #(
    parameter int unsigned N    = 24,
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 4,
    parameter int unsigned CW   = 16
) (
    input logic                clk,
    input logic                rst,
    reg_write_arbiter_if.slave bus
);
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREG = 2 ** AW;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   ptrNext;
    logic            anyGnt;
    logic [NREQ-1:0] gntVec;
    logic [AW-1:0]   selAddr;
    logic [N-1:0]    selData;
    logic [NREG-1:0] wenNext;
    int              idx;

    logic            weReg;
    logic [AW-1:0]   waddrReg;
    logic [N-1:0]    wdataReg;
    logic [NREG-1:0] wenReg;
    logic [CW-1:0]   wrCount;

    // Search starts at ptr and wraps; the first asserted request wins.
    always_comb begin
        gntVec = '0;
        winner = '0;
        anyGnt = 1'b0;
        idx    = 0;
        if (!bus.stall && !rst) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                idx = (int'(ptr) + i) % int'(NREQ);
                if (!anyGnt && bus.req[idx]) begin
                    anyGnt      = 1'b1;
                    winner      = PW'(idx);
                    gntVec[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        selAddr = bus.req_addr[int'(winner) * int'(AW) +: AW];
        selData = bus.req_data[int'(winner) * int'(N) +: N];
        ptrNext = (int'(winner) == int'(NREQ) - 1) ? '0 : winner + 1'b1;
        wenNext = '0;
        wenNext[selAddr] = 1'b1;
    end

    // waddr/wdata hold on idle cycles; only the strobe and enables drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            weReg    <= 1'b0;
            waddrReg <= '0;
            wdataReg <= '0;
            wenReg   <= '0;
            wrCount  <= '0;
        end else if (anyGnt) begin
            ptr      <= ptrNext;
            weReg    <= 1'b1;
            waddrReg <= selAddr;
            wdataReg <= selData;
            wenReg   <= wenNext;
            wrCount  <= wrCount + 1'b1;
        end else begin
            weReg  <= 1'b0;
            wenReg <= '0;
        end
    end

    assign bus.gnt      = gntVec;
    assign bus.we       = weReg;
    assign bus.waddr    = waddrReg;
    assign bus.wdata    = wdataReg;
    assign bus.wen_vec  = wenReg;
    assign bus.wr_count = wrCount;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios plus randomized traffic,
// with a round-robin reference model and a bank image built from the DUT enables.
module tb_reg_write_arbiter;
    localparam int unsigned N    = 24;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 4;
    localparam int unsigned CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_write_arbiter_if #(.N(N), .NREQ(NREQ), .AW(AW), .CW(CW)) bus ();

    reg_write_arbiter #(.N(N), .NREQ(NREQ), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        logic [CW-1:0] cnt;
    } wr_t;

    wr_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    // Requester-side state and reference model
    logic [NREQ-1:0] reqV;
    logic            stallV;
    logic [AW-1:0]   reqA[NREQ];
    logic [N-1:0]    reqD[NREQ];
    int              lastGnt;
    logic [CW-1:0]   modelCnt;
    logic [AW-1:0]   holdAddr;
    logic [N-1:0]    holdData;
    logic [CW-1:0]   holdCnt;
    logic [N-1:0]    bank[2**AW];
    wr_t             mon;
    logic [2**AW-1:0] expWen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner is the first requester after the previous winner, cyclically.
    function automatic int pickWinner();
        if (stallV || rst) return -1;
        for (int off = 1; off <= int'(NREQ); off++) begin
            int j;
            j = (lastGnt + off) % int'(NREQ);
            if (reqV[j]) return j;
        end
        return -1;
    endfunction

    task automatic driveInputs();
        bus.req   = reqV;
        bus.stall = stallV;
        for (int i = 0; i < int'(NREQ); i++) begin
            bus.req_addr[i*AW +: AW] = reqA[i];
            bus.req_data[i*N +: N]   = reqD[i];
        end
    endtask

    // Entered and left at posedge+3.
    task automatic step(output int k);
        logic [NREQ-1:0] expG;
        driveInputs();
        @(negedge clk);
        k    = pickWinner();
        expG = '0;
        if (k >= 0) expG[k] = 1'b1;
        check("gnt", bus.gnt, expG);
        if (k >= 0) begin
            modelCnt = modelCnt + 1'b1;
            expQ.push_back('{addr: reqA[k], data: reqD[k], cnt: modelCnt});
            lastGnt = k;
        end
        @(posedge clk);
        #3;
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        #1;
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.waddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_wen_vec", bus.wen_vec, 0);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_gnt", bus.gnt, 0);
        expQ.delete();
        lastGnt  = int'(NREQ) - 1;
        modelCnt = '0;
        holdAddr = '0;
        holdData = '0;
        holdCnt  = '0;
        repeat (cycles) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Monitor: compares registered outputs against the oldest expected write.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            check("we", bus.we, expQ.size() > 0);
            if (expQ.size() > 0) begin
                mon    = expQ.pop_front();
                expWen = '0;
                expWen[mon.addr] = 1'b1;
                check("waddr", bus.waddr, mon.addr);
                check("wdata", bus.wdata, mon.data);
                check("wen_vec", bus.wen_vec, expWen);
                check("wr_count", bus.wr_count, mon.cnt);
                holdAddr = mon.addr;
                holdData = mon.data;
                holdCnt  = mon.cnt;
            end else begin
                check("idle_wen_vec", bus.wen_vec, 0);
                check("idle_waddr", bus.waddr, holdAddr);
                check("idle_wdata", bus.wdata, holdData);
                check("idle_wr_count", bus.wr_count, holdCnt);
            end
            for (int r = 0; r < 2**AW; r++)
                if (bus.wen_vec[r]) bank[r] = bus.wdata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        reqV   = '0;
        stallV = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            reqA[i] = '0;
            reqD[i] = '0;
        end
        for (int r = 0; r < 2**AW; r++) bank[r] = '0;
        driveInputs();
        #1 rst = 1'b1;
        @(posedge clk);
        #3;
        doReset(2);

        // Single requester
        reqA[0] = 4'd3;
        reqD[0] = 24'h011111;
        reqV    = 4'b0001;
        step(k);
        reqV = '0;
        step(k);

        // Round-robin with all four requesting, back-to-back
        doReset(1);
        for (int i = 0; i < int'(NREQ); i++) begin
            reqA[i] = AW'(i + 8);
            reqD[i] = N'($urandom);
        end
        reqV = '1;
        for (int c = 0; c < 8; c++) begin
            step(k);
            if (k >= 0) reqD[k] = N'($urandom);
        end
        reqV = '0;
        step(k);

        // Stall after granting 1
        doReset(1);
        reqV = '1;
        step(k);
        step(k);
        stallV = 1'b1;
        repeat (3) step(k);
        stallV = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(k);
            if (k >= 0) reqV[k] = 1'b0;
        end
        step(k);

        // Address conflict: both write register 5, requester 2 lands last
        doReset(1);
        reqA[0] = 4'd5;
        reqD[0] = 24'hAAAAA;
        reqA[2] = 4'd5;
        reqD[2] = 24'h44444;
        reqV    = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            step(k);
            if (k >= 0) reqV[k] = 1'b0;
        end
        step(k);
        check("bank5", bank[5], 24'h44444);

        // Counter wrap with a 4-bit counter
        doReset(1);
        reqV = 4'b0001;
        for (int c = 0; c < 17; c++) begin
            reqA[0] = AW'($urandom);
            reqD[0] = N'($urandom);
            step(k);
        end
        reqV = '0;
        step(k);
        check("wrap_count", bus.wr_count, 1);

        // Randomized traffic with a reset in the middle
        doReset(1);
        for (int c = 0; c < 400; c++) begin
            if (c == 200) doReset(2);
            stallV = ($urandom_range(0, 4) == 0);
            step(k);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (i == k) begin
                    reqV[i] = ($urandom_range(0, 1) == 1);
                    reqA[i] = AW'($urandom);
                    reqD[i] = N'($urandom);
                end else if (!reqV[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        reqV[i] = 1'b1;
                        reqA[i] = AW'($urandom);
                        reqD[i] = N'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    reqV[i] = 1'b0;
                end
            end
        end
        reqV   = '0;
        stallV = 1'b0;
        step(k);
        step(k);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the SIMD register bank among several requesters, such as the vector ALU, the load unit and the AES key-schedule unit. It accepts one write per cycle and registers the winning address and data. It drives a one-hot per-register enable vector straight into the `en` inputs of the bank's `register` instances. It also keeps a wrapping count of completed writes for debug.

## Interface
- N, 24: data width of each register
- NREQ, 4: number of requesters (2..8)
- AW, 4: register address width; the bank has 2**AW registers
- CW, 16: width of the write counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- req  in  NREQ  per-requester write request; held high until granted
- req_addr  in  NREQ*AW  requester i's address in bits [i*AW +: AW]
- req_data  in  NREQ*N  requester i's data in bits [i*N +: N]
- stall  in  1  datapath hold; while high, no grant is issued
- gnt  out  NREQ  one-hot grant, combinational, same cycle as acceptance
- we  out  1  registered write strobe to the bank
- waddr  out  AW  registered write address
- wdata  out  N  registered write data; drives the bank's D inputs
- wen_vec  out  2**AW  registered one-hot decode of waddr, gated by we
- wr_count  out  CW  number of accepted writes, wraps modulo 2**CW

## Operation
- State:
  - round-robin pointer `ptr` (0..NREQ-1)
  - output registers we, waddr, wdata, wen_vec
  - wr_count
- Arbitration (combinational, every cycle):
  - If stall=1, rst=1 or req=0, then gnt=0.
  - Otherwise, search requesters in the order ptr, ptr+1, … modulo NREQ. The first one with req set wins, and only its gnt bit goes high.
- On a clock edge with a grant to requester k:
  - we←1, waddr←req_addr[k], wdata←req_data[k]
  - wen_vec←one-hot(req_addr[k])
  - ptr←(k+1) mod NREQ
  - wr_count←wr_count+1, wrapping all-ones→0
- On a clock edge without a grant:
  - we←0, wen_vec←0
  - waddr and wdata hold their last values
  - ptr and wr_count hold
- Requester protocol:
  - A requester keeps req, addr and data stable until it sees gnt high in a cycle; that edge is the transfer.
  - It may keep req high with new addr/data in the next cycle to issue back-to-back writes. These are still subject to round-robin.
  - Dropping req before gnt withdraws the request. This is legal, and nothing is written.
- Same address from several requesters: there is no merging. Each write is granted in round-robin order, and the last one granted wins in the bank.
- stall has priority over all requests. Pending requests are neither lost nor reordered, and ptr is frozen.
- Reset (asynchronous, any time including mid-transfer):
  - we=0, waddr=0, wdata=0, wen_vec=0, ptr=0, wr_count=0, gnt=0 while rst is high.
  - A write granted in the cycle rst asserts is discarded. The requester still holds req, so it is re-arbitrated after release.

## Timing
- Grant: combinational in cycle t.
- Write strobe: we, wen_vec, waddr and wdata are valid in cycle t+1, so the bank register updates at the end of t+1. Request-to-bank-update latency is 2 edges.
- Throughput: 1 write per cycle when unstalled. Each requester gets at most 1 grant per NREQ cycles while all NREQ are requesting.
- No combinational path from req to we; outputs to the bank are purely registered.
- stall rising in cycle t blocks the grant in cycle t. Therefore we=0 in t+1.
- First grant after rst deasserts: the first rising edge with rst low.

## Test plan
- **Reset values:** pulse rst for 2 cycles mid-operation, between clock edges → we=0, wen_vec=0, waddr=0, wdata=0, wr_count=0, gnt=0 immediately, without waiting for a clock edge.
- **Single requester:** req=0001, addr0=3, data0=24'h11111 → gnt=0001 in the same cycle. Next cycle: we=1, waddr=3, wdata=24'h11111, wen_vec=16'h0008, wr_count=1.
- **Round-robin fairness:** all 4 requesters held high for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; wr_count=8.
- **Stall:** all requesting, stall=1 for 3 cycles after granting 1 → gnt=0 and we=0 during the stall. First grant after stall=0 goes to requester 2; no request is lost.
- **Address conflict:** req0 and req2 both write addr 5, data 24'hAAAAA and 24'h44444, ptr=0 → requester 0 is written first, then requester 2. The final bank value at 5 is 24'h44444.
- **Counter wrap:** CW=4, 17 consecutive grants → wr_count goes 15→0 and then reads 1.
